// File: rtl/instruction_prefetch_pkg.sv
// Shared constants for the instruction prefetch stage: default depth and
// the opcode patterns that identify two-word instructions (used with TWO_WORD_EN).
package instruction_prefetch_pkg;

    localparam int PREFETCH_DEPTH_DEFAULT = 4;

    // LDS/STS: 1001_00x_xxxxx_0000    JMP/CALL: 1001_010x_xxxx_11xx
    localparam logic [15:0] TWO_WORD_LDS_MASK  = 16'hFC0F;
    localparam logic [15:0] TWO_WORD_LDS_MATCH = 16'h9000;
    localparam logic [15:0] TWO_WORD_JMP_MASK  = 16'hFE0C;
    localparam logic [15:0] TWO_WORD_JMP_MATCH = 16'h940C;

    function automatic logic is_two_word(input logic [15:0] word);
        return ((word & TWO_WORD_LDS_MASK) == TWO_WORD_LDS_MATCH) ||
               ((word & TWO_WORD_JMP_MASK) == TWO_WORD_JMP_MATCH);
    endfunction

endpackage

// File: rtl/instruction_prefetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with single push, pop by one or two,
// synchronous clear, occupancy level and head / head+1 read ports.
module instruction_prefetch_fifo #(
    parameter int IW    = 16,
    parameter int AW    = 10,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [IW-1:0] push_instr,
    input  logic [AW-1:0] push_pc,
    input  logic          pop,
    input  logic          pop2,
    output logic [LW-1:0] level,
    output logic [IW-1:0] head_instr,
    output logic [AW-1:0] head_pc,
    output logic [IW-1:0] next_instr
);
    localparam int PW = $clog2(DEPTH);

    logic [IW-1:0] mem_instr [DEPTH];
    logic [AW-1:0] mem_pc    [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] pop_cnt;
    logic [LW-1:0] push_cnt;

    always_comb begin
        pop_cnt  = '0;
        if (pop) pop_cnt = pop2 ? LW'(2) : LW'(1);
        push_cnt = LW'(push);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            // pointers wrap naturally because DEPTH is a power of two
            rd_ptr <= rd_ptr + pop_cnt[PW-1:0];
            level  <= level + push_cnt - pop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= push_instr;
            mem_pc[wr_ptr]    <= push_pc;
        end
    end

    assign head_instr = mem_instr[rd_ptr];
    assign head_pc    = mem_pc[rd_ptr];
    assign next_instr = mem_instr[rd_ptr + PW'(1)];

    // Issue throttling upstream guarantees neither of these can fire.
    always_ff @(posedge clk) begin
        if (!reset && !clear) begin
            assert (!(push && !pop && level == LW'(DEPTH)));
            assert (level >= pop_cnt);
        end
    end

endmodule

// File: rtl/instruction_prefetch.sv
// Fetch stage: ROM address issue, 1-cycle response tracking, redirect flush and
// valid/ready presentation to decode. TWO_WORD_EN enables two-word opcode pairing.
module instruction_prefetch
    import instruction_prefetch_pkg::*;
#(
    parameter int INSTR_WIDTH  = 16,
    parameter int I_ADDR_WIDTH = 10,
    parameter int DEPTH        = PREFETCH_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [I_ADDR_WIDTH-1:0]   rom_addr,
    input  logic [INSTR_WIDTH-1:0]    rom_data,
    output logic [INSTR_WIDTH-1:0]    instr_out,
    output logic [INSTR_WIDTH-1:0]    instr_ext,
    output logic [I_ADDR_WIDTH-1:0]   instr_pc,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    input  logic                      redirect,
    input  logic [I_ADDR_WIDTH-1:0]   redirect_pc,
    output logic [$clog2(DEPTH):0]    fifo_level
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [I_ADDR_WIDTH-1:0] fetch_pc;
    logic [I_ADDR_WIDTH-1:0] req_pc_q;
    logic                    req_q;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    pop2;
    logic                    valid;
    logic [INSTR_WIDTH-1:0]  head_instr;
    logic [I_ADDR_WIDTH-1:0] head_pc;
    logic [INSTR_WIDTH-1:0]  next_instr;
    logic [INSTR_WIDTH-1:0]  ext;

    // A redirect always issues: it flushes the FIFO, so space is guaranteed.
    always_comb begin
        rom_addr = reset ? '0 : (redirect ? redirect_pc : fetch_pc);
        issue    = !reset &&
                   (redirect || (({1'b0, fifo_level} + (LW+1)'(req_q)) < (LW+1)'(DEPTH)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= '0;
            req_pc_q <= '0;
            req_q    <= 1'b0;
        end else begin
            req_q <= issue;
            if (issue) begin
                req_pc_q <= rom_addr;
                fetch_pc <= rom_addr + I_ADDR_WIDTH'(1);
            end
        end
    end

`ifdef TWO_WORD_EN
    logic head_two;

    always_comb begin
        head_two = is_two_word(head_instr);
        valid    = head_two ? (fifo_level >= LW'(2)) : (fifo_level != '0);
        pop2     = head_two;
        ext      = (valid && head_two) ? next_instr : '0;
    end
`else
    logic unused_next;

    always_comb begin
        valid       = (fifo_level != '0);
        pop2        = 1'b0;
        ext         = '0;
        unused_next = ^next_instr;
    end
`endif

    always_comb begin
        push        = req_q && !redirect;
        pop         = valid && instr_ready && !redirect;
        instr_valid = valid;
        instr_out   = valid ? head_instr : '0;
        instr_pc    = valid ? head_pc : '0;
        instr_ext   = ext;
    end

    instruction_prefetch_fifo #(
        .IW    (INSTR_WIDTH),
        .AW    (I_ADDR_WIDTH),
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect),
        .push       (push),
        .push_instr (rom_data),
        .push_pc    (req_pc_q),
        .pop        (pop),
        .pop2       (pop2),
        .level      (fifo_level),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .next_instr (next_instr)
    );

endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: directed latency/stall/redirect/wrap/reset steps,
// then random ready/redirect traffic checked against an in-order program-stream model.
module tb_instruction_prefetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr_out;
    logic [15:0] instr_ext;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic [2:0]  fifo_level;

    logic [15:0] rom [1024];
    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;
    logic [9:0]  exp_pc;
    int          accepts = 0;

    instruction_prefetch dut (
        .clk         (clk),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr_out   (instr_out),
        .instr_ext   (instr_ext),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: one-cycle read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Program-order model: every accepted word must be the next sequential PC
    // (or the redirect target) and carry that address's ROM contents.
    task automatic cycle();
        if (!reset && !redirect && instr_valid && instr_ready) begin
            check("acc_pc", {22'd0, instr_pc}, {22'd0, exp_pc});
            check("acc_data", {16'd0, instr_out}, {16'd0, rom[exp_pc]});
            exp_pc = exp_pc + 10'd1;
            accepts++;
        end
        if (reset) exp_pc = '0;
        else if (redirect) exp_pc = redirect_pc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] a8;
        logic [9:0] wrap_exp [4];
        int         a0;
        logic       prev_redir;

        for (int k = 0; k < 1024; k++) rom[k] = 16'h1000 + 16'(k);
        wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;
        exp_pc      = '0;
        reset       = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 10'h155;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_out", {16'd0, instr_out}, 32'd0);
        check("rst_pc", {22'd0, instr_pc}, 32'd0);
        check("rst_ext", {16'd0, instr_ext}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);

        // cycle R: reset released
        redirect    = 1'b0;
        reset       = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("R_rom_addr", {22'd0, rom_addr}, 32'd0);
        check("R_valid", {31'd0, instr_valid}, 32'd0);
        cycle();
        #1;
        check("R1_valid", {31'd0, instr_valid}, 32'd0);
        cycle();
        #1;
        check("R2_valid", {31'd0, instr_valid}, 32'd1);
        check("R2_pc", {22'd0, instr_pc}, 32'd0);
        check("R2_out", {16'd0, instr_out}, 32'h1000);
        cycle();
        for (int i = 0; i < 6; i++) begin
            #1;
            check("stream_valid", {31'd0, instr_valid}, 32'd1);
            cycle();
        end

        // stall: FIFO saturates and issue stops
        instr_ready = 1'b0;
        a8 = '0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (i == 8) a8 = rom_addr;
            cycle();
        end
        #1;
        check("stall_level", {29'd0, fifo_level}, 32'd4);
        check("stall_addr_held", {22'd0, rom_addr}, {22'd0, a8});
        instr_ready = 1'b1;
        a0 = accepts;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_valid", {31'd0, instr_valid}, 32'd1);
            cycle();
        end
        check("drain_count", 32'(accepts - a0), 32'd4);

        // redirect while full, with ready high in the same cycle
        instr_ready = 1'b0;
        repeat (8) begin #1; cycle(); end
        #1;
        check("pre_redir_level", {29'd0, fifo_level}, 32'd4);
        redirect    = 1'b1;
        redirect_pc = 10'h200;
        instr_ready = 1'b1;
        #1;
        check("redir_rom_addr", {22'd0, rom_addr}, 32'h200);
        a0 = accepts;
        cycle();
        redirect = 1'b0;
        #1;
        check("redir_n1_valid", {31'd0, instr_valid}, 32'd0);
        check("redir_n1_level", {29'd0, fifo_level}, 32'd0);
        check("redir_no_pop", 32'(accepts - a0), 32'd0);
        cycle();
        #1;
        check("redir_n2_valid", {31'd0, instr_valid}, 32'd1);
        check("redir_n2_pc", {22'd0, instr_pc}, 32'h200);
        cycle();

        // PC wrap
        redirect    = 1'b1;
        redirect_pc = 10'h3FE;
        #1;
        cycle();
        redirect = 1'b0;
        #1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("wrap_pc", {22'd0, instr_pc}, {22'd0, wrap_exp[i]});
            cycle();
        end

        // reset mid-stream at level 3
        instr_ready = 1'b0;
        for (int i = 0; i < 10 && fifo_level != 3'd3; i++) begin
            #1;
            cycle();
        end
        check("mid_level3", {29'd0, fifo_level}, 32'd3);
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 10'h0AA;
        instr_ready = 1'b1;
        #1;
        cycle();
        check("mid_rst_level", {29'd0, fifo_level}, 32'd0);
        check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_rom_addr", {22'd0, rom_addr}, 32'd0);
        redirect = 1'b0;
        reset    = 1'b0;

        // random ready / redirect traffic
        prev_redir = 1'b0;
        for (int i = 0; i < 500; i++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 10'($urandom);
            #1;
            check("rand_level_max", {31'd0, (fifo_level <= 3'd4)}, 32'd1);
            if (prev_redir) check("rand_redir_gap", {31'd0, instr_valid}, 32'd0);
`ifndef TWO_WORD_EN
            check("rand_ext_zero", {16'd0, instr_ext}, 32'd0);
`endif
            prev_redir = redirect;
            cycle();
        end
        redirect = 1'b0;

`ifdef TWO_WORD_EN
        rom[0] = 16'h940C;
        rom[1] = 16'h0123;
        reset       = 1'b1;
        instr_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("tw_valid", {31'd0, instr_valid}, 32'd1);
        check("tw_out", {16'd0, instr_out}, 32'h940C);
        check("tw_ext", {16'd0, instr_ext}, 32'h0123);
        check("tw_pc", {22'd0, instr_pc}, 32'd0);
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        check("tw_next_pc", {22'd0, instr_pc}, 32'd2);
        check("tw_next_ext", {16'd0, instr_ext}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch.md
Name: instruction_prefetch

Overview:
- Fetch stage between the instruction ROM and the control unit.
- Drives the ROM address, absorbs the ROM's 1-cycle synchronous read latency, and buffers fetched words in a small FIFO.
- Presents instructions to decode with a valid/ready handshake, so decode may stall without losing fetches.
- Accepts a redirect (jump/branch/call/ret target) that flushes all buffered and in-flight words.

Parameters:
- INSTR_WIDTH, 16, instruction word width.
- I_ADDR_WIDTH, 10, ROM word-address width; PC width.
- DEPTH, 4, FIFO entries; power of two; minimum 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_addr  output  I_ADDR_WIDTH  address to ROM; ROM returns the word one cycle later.
- rom_data  input  INSTR_WIDTH  ROM read data for the address presented in the previous cycle.
- instr_out  output  INSTR_WIDTH  FIFO head instruction word.
- instr_ext  output  INSTR_WIDTH  second word of a two-word instruction (see Optional Feature).
- instr_pc  output  I_ADDR_WIDTH  address of instr_out.
- instr_valid  output  1  head entry is valid.
- instr_ready  input  1  decode accepts the head this cycle.
- redirect  input  1  flush and refetch from redirect_pc.
- redirect_pc  input  I_ADDR_WIDTH  new fetch address.
- fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=1 at an edge):
  - fetch_pc=0, req_q=0, FIFO empty, fifo_level=0.
  - instr_valid=0; instr_out, instr_ext and instr_pc all 0.
  - rom_addr=0 while reset is held.
- Issue:
  - Condition: fifo_level + req_q < DEPTH and not reset. This is conservative; a same-cycle pop is not counted.
  - rom_addr = redirect ? redirect_pc : fetch_pc (combinational mux).
  - On issue: req_q<=1, req_pc_q<=rom_addr, fetch_pc<=rom_addr+1. Wraps modulo 2^I_ADDR_WIDTH (1023 -> 0).
  - No issue: req_q<=0, fetch_pc held.
- Push: when req_q=1 and redirect=0, write {rom_data, req_pc_q} to the FIFO tail. Overflow is impossible by construction; assert this in simulation.
- Pop: when instr_valid && instr_ready && !redirect, advance head.
- Same-cycle push and pop: fifo_level unchanged.
- instr_valid = (fifo_level != 0). instr_out and instr_pc are forced to 0 when instr_valid=0.
- Redirect in cycle N:
  - FIFO cleared; the in-flight response (req_q) is discarded.
  - redirect_pc is issued in cycle N; its word is pushed at the end of N+1; instr_valid=1 in N+2.
  - Redirect has priority over pop and push in the same cycle.
  - Back-to-back redirects: the last one wins.
- Throughput: 1 instruction/cycle sustained with instr_ready held high, after a 2-cycle fill.
- After reset deasserts at cycle R: address 0 is issued in R, and the word is valid in R+2.
- instr_ready high while instr_valid=0 has no effect.
- Reset mid-operation clears all state in one edge regardless of redirect or handshake inputs.

Optional Feature:
- Macro: TWO_WORD_EN.
- Defined:
  - The head is decoded for two-word opcodes: LDS/STS (1001_00x_xxxxx_0000) and JMP/CALL (1001_010x_xxxx_11xx).
  - For such a head, instr_valid=1 only when fifo_level>=2.
  - instr_ext = entry head+1; instr_pc = PC of the first word.
  - A pop removes 2 entries.
  - For single-word opcodes, instr_ext=0.
- Not defined: every word is presented individually and instr_ext is tied to 0.

Decomposition:
- Shared include defines.vh holds:
  - `TWO_WORD_LDS_MASK/`TWO_WORD_LDS_MATCH
  - `TWO_WORD_JMP_MASK/`TWO_WORD_JMP_MATCH
  - `PREFETCH_DEPTH_DEFAULT
- Sub-module prefetch_fifo: synchronous FIFO of {pc,instr} entries with push, pop (by 1 or 2), clear, level, and head/head+1 outputs.
- The top handles issue control, the redirect mux and response tracking.

Test Plan:
- Reset, then instr_ready=1, ROM[k]=k+16'h1000 -> instr_valid rises 2 cycles after reset deasserts; then instr_out=1000,1001,1002… each cycle with instr_pc=0,1,2….
- instr_ready=0 for 10 cycles -> fifo_level saturates at 4 and rom_addr stops advancing; releasing ready drains PC 0..3 in order with no gaps or duplicates.
- Redirect to 10'h200 while the FIFO is full and ready=1 in the same cycle -> no pop occurs; instr_valid=0 next cycle; instr_pc=200 exactly 2 cycles after redirect; no stale word appears.
- Start at fetch_pc=10'h3FE with ready=1 -> instr_pc sequence 3FE, 3FF, 000, 001.
- Reset asserted mid-stream with FIFO at level 3 -> next cycle fifo_level=0, instr_valid=0, rom_addr=0.
- TWO_WORD_EN defined, ROM[0]=16'h940C (JMP), ROM[1]=16'h0123 -> a single accept with instr_out=940C, instr_ext=0123, instr_pc=0; the next instr_pc=2.
